// File: rtl/ram8_fifo_pkg.sv
// Shared sizing for the 8-word RAM-backed FIFO controller.
package ram8_fifo_pkg;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int DW    = 16;
   localparam int CW    = 4;

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
endpackage

// File: rtl/ram8_fifo_ptr.sv
// Wrapping RAM address counter; advances by one when en is high.
module ram8_fifo_ptr
   import ram8_fifo_pkg::*;
(
   input  logic          clock,
   input  logic          reset_n,
   input  logic          en,
   output logic [AW-1:0] ptr
);

   // Natural overflow of the 3-bit register gives the 7 -> 0 wrap.
   always_ff @(posedge clock) begin
      if (!reset_n)
         ptr <= '0;
      else if (en)
         ptr <= ptr + AW'(1);
   end

endmodule

// File: rtl/ram8_fifo_ctrl.sv
// FIFO controller using an external single-port 8x16 RAM plus a one-word output register.
module ram8_fifo_ctrl
   import ram8_fifo_pkg::*;
(
   input  logic          clock,
   input  logic          reset_n,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] mem_in,
   output logic [AW-1:0] mem_address,
   output logic          mem_load,
   input  logic [DW-1:0] mem_out
);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          prefetch;
   logic          push;
   logic          pop;

   // Refilling the output register owns the RAM port; pushes wait a cycle.
   // Gating with reset_n keeps the RAM idle and the input closed during reset.
   assign prefetch = reset_n && (count != '0) && (!out_valid || out_ready);
   assign in_ready = reset_n && (count != FULL_COUNT) && !prefetch;
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   assign mem_address = prefetch ? rd_ptr : wr_ptr;
   assign mem_load    = push;
   assign mem_in      = in_data;

   ram8_fifo_ptr u_wr_ptr (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (push),
      .ptr     (wr_ptr)
   );

   ram8_fifo_ptr u_rd_ptr (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (prefetch),
      .ptr     (rd_ptr)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (prefetch) begin
            out_data  <= mem_out;
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
         count <= count + CW'(push) - CW'(prefetch);
      end
   end

endmodule
